// File: rtl/mxv_frame_controller.sv
// Frame decoder for a matrix-vector engine: parses FE/LEN/CMD/payload/EF frames from an RX FIFO,
// loads operands, starts the compute and returns results. MXV_CTRL_ERR_RESP_EN drives resend_req.
module mxv_frame_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_pop,
  output logic [3:0]  dim_n,
  output logic [7:0]  wr_data,
  output logic        mat_wr_en,
  output logic [5:0]  mat_wr_addr,
  output logic        vec_wr_en,
  output logic [2:0]  vec_wr_addr,
  output logic        calc_start,
  input  logic        calc_done,
  output logic [2:0]  res_rd_addr,
  input  logic [15:0] res_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        resend_req
);

  localparam logic [7:0] Sof     = 8'hFE;
  localparam logic [7:0] Eof     = 8'hEF;
  localparam logic [7:0] CmdSetN = 8'h01;
  localparam logic [7:0] CmdArm  = 8'h03;
  localparam logic [7:0] CmdLoad = 8'h04;

  typedef enum logic [2:0] {
    StIdle, StGetLen, StGetCmd, StPayload, StGetEof, StCalc, StTx, StDiscard
  } state_e;

  state_e      r_state, w_state_d;
  logic [7:0]  r_cnt, w_cnt_d;
  logic [7:0]  r_cmd, w_cmd_d;
  logic [6:0]  r_ptr, w_ptr_d;
  logic        r_armed, w_armed_d;
  logic [3:0]  r_dim, w_dim_d;
  logic [3:0]  r_newn, w_newn_d;
  logic [4:0]  r_tx_idx, w_tx_idx_d;
  logic        r_mat_en, w_mat_en_d;
  logic [5:0]  r_mat_addr, w_mat_addr_d;
  logic        r_vec_en, w_vec_en_d;
  logic [2:0]  r_vec_addr, w_vec_addr_d;
  logic [7:0]  r_wr_data, w_wr_data_d;
  logic        r_calc, w_calc_d;
  logic        w_err;
  logic        w_pop;
  logic [6:0]  w_nn;
  logic [6:0]  w_limit;
  logic [4:0]  w_tx_last;

  assign w_nn      = {3'b000, r_dim} * {3'b000, r_dim};
  assign w_limit   = w_nn + {3'b000, r_dim};
  assign w_tx_last = {r_dim, 1'b0} + 5'd2;

  assign w_pop  = rx_valid & ~rst & (r_state != StCalc) & (r_state != StTx);
  assign rx_pop = w_pop;

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_cmd_d      = r_cmd;
    w_ptr_d      = r_ptr;
    w_armed_d    = r_armed;
    w_dim_d      = r_dim;
    w_newn_d     = r_newn;
    w_tx_idx_d   = r_tx_idx;
    w_mat_en_d   = 1'b0;
    w_mat_addr_d = r_mat_addr;
    w_vec_en_d   = 1'b0;
    w_vec_addr_d = r_vec_addr;
    w_wr_data_d  = r_wr_data;
    w_calc_d     = 1'b0;
    w_err        = 1'b0;
    unique case (r_state)
      StIdle: if (w_pop && rx_data == Sof) w_state_d = StGetLen;
      StGetLen: if (w_pop) begin
        if (rx_data < 8'd2) begin
          w_err = 1'b1;
        end else begin
          w_cnt_d   = rx_data - 8'd2;
          w_state_d = StGetCmd;
        end
      end
      StGetCmd: if (w_pop) begin
        w_cmd_d = rx_data;
        case (rx_data)
          CmdSetN: if (r_cnt != 8'd1) w_err = 1'b1; else w_state_d = StPayload;
          CmdArm:  if (r_cnt != 8'd0) w_err = 1'b1; else w_state_d = StGetEof;
          CmdLoad: begin
            if (!r_armed)            w_err = 1'b1;
            else if (r_cnt == 8'd0)  w_state_d = StGetEof;
            else                     w_state_d = StPayload;
          end
          default: w_err = 1'b1;
        endcase
      end
      StPayload: if (w_pop) begin
        w_cnt_d = r_cnt - 8'd1;
        if (r_cnt == 8'd1) w_state_d = StGetEof;
        if (r_cmd == CmdSetN) begin
          if (rx_data == 8'd0 || rx_data > 8'd8) w_err = 1'b1;
          else w_newn_d = rx_data[3:0];
        end else if (r_ptr >= w_limit) begin
          w_err = 1'b1;
        end else begin
          w_wr_data_d = rx_data;
          w_ptr_d     = r_ptr + 7'd1;
          if (r_ptr < w_nn) begin
            w_mat_en_d   = 1'b1;
            w_mat_addr_d = r_ptr[5:0];
          end else begin
            // Offset below N fits in 3 bits, so modulo-8 subtraction is exact.
            w_vec_en_d   = 1'b1;
            w_vec_addr_d = r_ptr[2:0] - w_nn[2:0];
          end
        end
      end
      StGetEof: if (w_pop) begin
        if (rx_data != Eof) begin
          w_err = 1'b1;
        end else begin
          w_state_d = StIdle;
          case (r_cmd)
            CmdSetN: begin
              w_dim_d   = r_newn;
              w_armed_d = 1'b0;
              w_ptr_d   = 7'd0;
            end
            CmdArm: begin
              w_armed_d = 1'b1;
              w_ptr_d   = 7'd0;
            end
            default: begin
              if (r_armed && r_ptr == w_limit) begin
                w_calc_d  = 1'b1;
                w_state_d = StCalc;
              end
            end
          endcase
        end
      end
      StCalc: if (calc_done) begin
        w_state_d  = StTx;
        w_tx_idx_d = 5'd0;
      end
      StTx: if (tx_ready) begin
        if (r_tx_idx == w_tx_last) begin
          w_state_d = StIdle;
          w_armed_d = 1'b0;
        end else begin
          w_tx_idx_d = r_tx_idx + 5'd1;
        end
      end
      StDiscard: if (w_pop && rx_data == Eof) w_state_d = StIdle;
    endcase
    if (w_err) begin
      w_state_d = StDiscard;
      w_armed_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_cnt      <= 8'd0;
      r_cmd      <= 8'd0;
      r_ptr      <= 7'd0;
      r_armed    <= 1'b0;
      r_dim      <= 4'd4;
      r_newn     <= 4'd0;
      r_tx_idx   <= 5'd0;
      r_mat_en   <= 1'b0;
      r_mat_addr <= 6'd0;
      r_vec_en   <= 1'b0;
      r_vec_addr <= 3'd0;
      r_wr_data  <= 8'd0;
      r_calc     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_cmd      <= w_cmd_d;
      r_ptr      <= w_ptr_d;
      r_armed    <= w_armed_d;
      r_dim      <= w_dim_d;
      r_newn     <= w_newn_d;
      r_tx_idx   <= w_tx_idx_d;
      r_mat_en   <= w_mat_en_d;
      r_mat_addr <= w_mat_addr_d;
      r_vec_en   <= w_vec_en_d;
      r_vec_addr <= w_vec_addr_d;
      r_wr_data  <= w_wr_data_d;
      r_calc     <= w_calc_d;
    end
  end

  // TX byte index: 0 SOF, 1 length, 2..2N+1 result bytes (high first), 2N+2 EOF.
  always_comb begin
    tx_data     = 8'd0;
    res_rd_addr = 3'd0;
    if (r_state == StTx && !rst) begin
      if (r_tx_idx == 5'd0) begin
        tx_data = Sof;
      end else if (r_tx_idx == 5'd1) begin
        tx_data = {3'b000, r_dim, 1'b1};
      end else if (r_tx_idx == w_tx_last) begin
        tx_data = Eof;
      end else begin
        res_rd_addr = r_tx_idx[3:1] - 3'd1;
        tx_data     = r_tx_idx[0] ? res_data[7:0] : res_data[15:8];
      end
    end
  end

  assign tx_valid    = (r_state == StTx) & ~rst;
  assign dim_n       = r_dim;
  assign wr_data     = r_wr_data;
  assign mat_wr_en   = r_mat_en;
  assign mat_wr_addr = r_mat_addr;
  assign vec_wr_en   = r_vec_en;
  assign vec_wr_addr = r_vec_addr;
  assign calc_start  = r_calc;

`ifdef MXV_CTRL_ERR_RESP_EN
  logic r_resend;
  always_ff @(posedge clk) begin
    if (rst) r_resend <= 1'b0;
    else     r_resend <= w_err;
  end
  assign resend_req = r_resend;
`else
  assign resend_req = 1'b0;
`endif

endmodule

// File: doc/mxv_frame_controller.md
MXV_FRAME_CONTROLLER -- requirements
Module: mxv_frame_controller

Interface
REQ-001 SHALL provide clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL provide rst  input  1  synchronous, active-high reset.
REQ-003 SHALL provide rx_valid  input  1  RX FIFO holds a byte.
REQ-004 SHALL provide rx_data  input  8  RX FIFO head byte.
REQ-005 SHALL provide rx_pop  output  1  consumes rx_data this cycle.
REQ-006 SHALL provide dim_n  output  4  configured dimension N (1..8).
REQ-007 SHALL provide wr_data  output  8  payload byte to datapath.
REQ-008 SHALL provide mat_wr_en / mat_wr_addr  output  1 / 6  matrix write strobe, row-major address.
REQ-009 SHALL provide vec_wr_en / vec_wr_addr  output  1 / 3  vector write strobe, address.
REQ-010 SHALL provide calc_start  output  1  one-cycle compute pulse.
REQ-011 SHALL provide calc_done  input  1  datapath finished.
REQ-012 SHALL provide res_rd_addr / res_data  output 3 / input 16  combinational result read.
REQ-013 SHALL provide tx_valid / tx_data / tx_ready  output 1 / output 8 / input 1  TX byte handshake.
REQ-014 SHALL provide resend_req  output  1  one-cycle protocol-error pulse.

Function
REQ-015 Frame format SHALL be 0xFE, LEN, CMD, payload, 0xEF; LEN counts CMD+payload+0xEF, payload = LEN-2 bytes.
REQ-016 FSM states SHALL be IDLE, GET_LEN, GET_CMD, PAYLOAD, GET_EOF, CALC, TX, DISCARD.
REQ-017 rx_pop SHALL equal rx_valid in IDLE..GET_EOF and DISCARD, and 0 in CALC/TX; each popped byte advances the FSM once.
REQ-018 IDLE SHALL drop bytes other than 0xFE; 0xFE -> GET_LEN.
REQ-019 LEN<2 SHALL be an error; else -> GET_CMD, payload counter = LEN-2.
REQ-020 CMD 0x01 (SET_N): payload exactly 1 byte, value 1..8; dim_n updates only when 0xEF is accepted.
REQ-021 CMD 0x03 (ARM): payload 0; on 0xEF clears load pointer to 0 and sets armed.
REQ-022 CMD 0x04 (LOAD): each payload byte written with the wr_*_en pulse in the pop cycle+1; pointer p<N*N -> matrix addr p, else vector addr p-N*N.
REQ-023 Pointer reaching N*N+N while armed SHALL, after frame 0xEF, pulse calc_start one cycle later and enter CALC.
REQ-024 LOAD while not armed, or p reaching N*N+N with bytes remaining, SHALL be an error; writes beyond limit are suppressed.
REQ-025 Unknown CMD, wrong payload count, N out of range, or byte after payload != 0xEF SHALL be an error.
REQ-026 Error: pulse resend_req (see REQ-033), clear armed, -> DISCARD; DISCARD drops bytes until 0xEF, then -> IDLE.
REQ-027 CALC SHALL wait for calc_done, then -> TX.
REQ-028 TX SHALL send 0xFE, 2N+1, then res_data[15:8], res_data[7:0] for addr 0..N-1, then 0xEF; byte advances only when tx_valid & tx_ready.
REQ-029 tx_valid SHALL stay high and tx_data stable until accepted; after 0xEF accepted -> IDLE, armed cleared.
REQ-030 New N (SET_N) SHALL clear armed and pointer.

Reset
REQ-031 rst SHALL force IDLE, dim_n=4, armed=0, pointer=0, and all strobes, rx_pop, tx_valid, calc_start, resend_req, addresses, wr_data, tx_data to 0.
REQ-032 rst mid-frame, in CALC, or in TX SHALL abandon the operation with no further writes or TX bytes.

Configuration
REQ-033 Macro MXV_CTRL_ERR_RESP_EN: defined -> resend_req pulses one cycle on each error; undefined -> resend_req tied 0, errors handled silently per REQ-026.

Verification
REQ-034 FE 03 01 04 EF -> dim_n=4 after EF; no writes.
REQ-035 FE 02 03 EF, FE 12 04 00..0F EF, FE 06 04 01 02 03 04 EF -> 16 matrix writes addr 0..15, 4 vector writes addr 0..3, calc_start once.
REQ-036 calc_done with res_data=0x0102 for all addr, tx_ready=1 -> TX FE 09 01 02 x4 EF (11 bytes); tx_ready toggling holds bytes.
REQ-037 FE 03 01 09 EF -> error, dim_n unchanged, resend_req=1 (macro) / 0 (no macro).
REQ-038 FE 03 01 04 55 -> DISCARD; following 33 EF FE 02 03 EF -> armed.
REQ-039 rst asserted during matrix LOAD -> no further mat_wr_en, dim_n=4, IDLE.
